// File: rtl/mcu_pkg.sv
// Shared constants and types for the multi-cycle control unit.
package mcu_pkg;

    // Opcode encodings; anything above OP_HALT is illegal.
    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_AND   = 1;
    localparam int unsigned OP_LOAD  = 2;
    localparam int unsigned OP_STORE = 3;
    localparam int unsigned OP_SUB   = 4;
    localparam int unsigned OP_OR    = 5;
    localparam int unsigned OP_BRZ   = 6;
    localparam int unsigned OP_HALT  = 7;

    // ALU operation select values.
    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_AND = 1;
    localparam int unsigned ALU_SUB = 2;
    localparam int unsigned ALU_OR  = 3;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CLASS_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_BRANCH,
        ST_HALT,
        ST_TRAP
    } state_e;

    typedef enum logic [CLASS_W-1:0] {
        CLS_ALU,
        CLS_MEM_LD,
        CLS_MEM_ST,
        CLS_BRZ,
        CLS_HALT,
        CLS_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/mcu_opcode_decode.sv
// Combinational opcode classifier: instruction class plus ALU select.
module mcu_opcode_decode
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned ALUOP_W  = 2
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output iclass_e             iclass_c_o,
    output logic [ALUOP_W-1:0]  alu_op_c_o
);

    // Map opcode to class; non-ALU classes and illegal opcodes select ADD.
    always_comb begin
        iclass_c_o = CLS_ILLEGAL;
        alu_op_c_o = ALUOP_W'(ALU_ADD);
        if (opcode_i == OPCODE_W'(OP_ADD)) begin
            iclass_c_o = CLS_ALU;
            alu_op_c_o = ALUOP_W'(ALU_ADD);
        end else if (opcode_i == OPCODE_W'(OP_AND)) begin
            iclass_c_o = CLS_ALU;
            alu_op_c_o = ALUOP_W'(ALU_AND);
        end else if (opcode_i == OPCODE_W'(OP_SUB)) begin
            iclass_c_o = CLS_ALU;
            alu_op_c_o = ALUOP_W'(ALU_SUB);
        end else if (opcode_i == OPCODE_W'(OP_OR)) begin
            iclass_c_o = CLS_ALU;
            alu_op_c_o = ALUOP_W'(ALU_OR);
        end else if (opcode_i == OPCODE_W'(OP_LOAD)) begin
            iclass_c_o = CLS_MEM_LD;
        end else if (opcode_i == OPCODE_W'(OP_STORE)) begin
            iclass_c_o = CLS_MEM_ST;
        end else if (opcode_i == OPCODE_W'(OP_BRZ)) begin
            iclass_c_o = CLS_BRZ;
        end else if (opcode_i == OPCODE_W'(OP_HALT)) begin
            iclass_c_o = CLS_HALT;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH/HALT.
// Optional MCU_ILLEGAL_TRAP_EN adds a TRAP state and an illegal_trap output;
// without it illegal opcodes retire as a NOP.
// Outputs decode from the state register and latched opcode; the only input
// terms are mem_ready (STORE completes in its ready cycle) and zero_flag
// (branch decision in the BRANCH cycle).
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                halted,
    output logic                busy
`ifdef MCU_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_trap
`endif
);

    state_e                state_q, state_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    iclass_e               iclass;
    logic [ALUOP_W-1:0]    dec_alu_op;

    mcu_opcode_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decode (
        .opcode_i   (opcode_q),
        .iclass_c_o (iclass),
        .alu_op_c_o (dec_alu_op)
    );

    // State and opcode latch; reset drops every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_op      = ALUOP_W'(ALU_ADD);
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        halted      = 1'b0;
        busy        = 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
        illegal_trap = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    opcode_d = opcode;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                busy = 1'b1;
                case (iclass)
                    CLS_ALU:    state_d = ST_EXEC;
                    CLS_MEM_LD: state_d = ST_MEM;
                    CLS_MEM_ST: state_d = ST_MEM;
                    CLS_BRZ:    state_d = ST_BRANCH;
                    CLS_HALT:   state_d = ST_HALT;
`ifdef MCU_ILLEGAL_TRAP_EN
                    CLS_ILLEGAL: state_d = ST_TRAP;
`else
                    CLS_ILLEGAL: state_d = ST_EXEC;
`endif
                    default:    state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                busy      = 1'b1;
                alu_op    = dec_alu_op;
                reg_write = (iclass == CLS_ALU);
                pc_inc    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = (iclass == CLS_MEM_ST);
                if (mem_ready) begin
                    if (iclass == CLS_MEM_ST) begin
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                pc_inc     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                busy    = 1'b1;
                alu_op  = ALUOP_W'(ALU_SUB);
                pc_load = zero_flag;
                pc_inc  = !zero_flag;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                busy         = 1'b1;
                illegal_trap = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
